ltcminer_nonce_hub: RTL and testbench

//  Multi-core successor to the single-core miner top: serves NUM_CORES hashcores.
//  - Drives a unique nonce prefix to each core.
//  - Collects golden-nonce pulses from all cores, arbitrates them round-robin and queues them in a FIFO.
//  - Presents results on a valid/ready stream to the host link.
//  - Cycles the LED progress display across cores.
//  - Sits between the hashcore array and the host comms block, in the hash_clk domain.

---
 rtl/ltcminer_nonce_hub_pkg.sv | 22 ++
 rtl/ltcminer_nonce_hub_fifo.sv | 60 ++++++
 rtl/ltcminer_nonce_hub.sv | 156 +++++++++++++++
 tb/tb_ltcminer_nonce_hub.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltcminer_nonce_hub_pkg.sv
// Shared constants and width helpers for the multi-core nonce hub.
package ltcminer_nonce_hub_pkg;

    localparam int NONCE_W_DEFAULT = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Core index width; a single core still gets a 1-bit index.
    function automatic int cidx_width(input int num_cores);
        return (num_cores <= 1) ? 1 : clog2(num_cores);
    endfunction

endpackage

// File: rtl/ltcminer_nonce_hub_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, full and empty flags.
module ltcminer_nonce_hub_fifo
    import ltcminer_nonce_hub_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ltcminer_nonce_hub.sv
// Multi-core nonce hub: per-core golden-nonce capture, round-robin arbitration into a
// result FIFO streamed to the host, and a rotating LED progress display.
module ltcminer_nonce_hub
    import ltcminer_nonce_hub_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int PREFIX_W   = 4,
    parameter int NONCE_W    = NONCE_W_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 8,
    parameter int LED_DIV    = 24,
    localparam int CIDX_W    = cidx_width(NUM_CORES)
) (
    input  logic                          hash_clk,
    input  logic                          reset,
    output logic [NUM_CORES*PREFIX_W-1:0] core_nonce_msb,
    input  logic [NUM_CORES*NONCE_W-1:0]  core_nonce,
    input  logic [NUM_CORES-1:0]          core_golden,
    output logic                          gn_valid,
    input  logic                          gn_ready,
    output logic [NONCE_W-1:0]            gn_nonce,
    output logic [CIDX_W-1:0]             gn_core,
    output logic [15:0]                   drop_cnt,
    output logic                          overflow,
    output logic [LED_W-1:0]              LEDS_out
);

    localparam int FIFO_AW = clog2(FIFO_DEPTH);
    localparam logic [CIDX_W-1:0]  CIDX_ONE  = CIDX_W'(1);
    localparam logic [LED_DIV-1:0] PRESC_ONE = LED_DIV'(1);

    if ((1 << PREFIX_W) < NUM_CORES) begin : g_prefix_check
        $error("PREFIX_W too narrow to give every core a unique prefix");
    end
    if (FIFO_DEPTH < 2 || (1 << FIFO_AW) != FIFO_DEPTH) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_prefix
        assign core_nonce_msb[i*PREFIX_W +: PREFIX_W] = PREFIX_W'(i);
    end

    logic [NUM_CORES-1:0]      pend_q, pend_d;
    logic [NONCE_W-1:0]        hold_q [NUM_CORES];
    logic [NONCE_W-1:0]        hold_d [NUM_CORES];
    logic [CIDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic                      push_vld_q;
    logic [CIDX_W+NONCE_W-1:0] push_data_q;
    logic [15:0]               drop_cnt_q, drop_cnt_d;
    logic                      overflow_q, overflow_d;
    logic [LED_DIV-1:0]        presc_q;
    logic [CIDX_W-1:0]         led_sel_q;
    logic [LED_W-1:0]          leds_q;

    logic                      space_ok;
    logic                      grant_vld;
    logic [CIDX_W-1:0]         grant_idx;
    logic [NUM_CORES-1:0]      grant;
    logic [4:0]                n_drop;
    logic [16:0]               drop_sum;
    logic [FIFO_AW:0]          fifo_count;
    logic                      fifo_full, fifo_empty;

    // A granted entry spends one cycle in the push register, so it counts as occupancy.
    assign space_ok = !fifo_full && ((int'(fifo_count) + int'(push_vld_q)) < FIFO_DEPTH);

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant     = '0;
        rr_ptr_d  = rr_ptr_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_vld && space_ok && pend_q[(int'(rr_ptr_q) + k) % NUM_CORES]) begin
                grant_vld = 1'b1;
                grant_idx = CIDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            grant[i] = grant_vld && (int'(grant_idx) == i);
        end
        if (grant_vld) begin
            rr_ptr_d = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + CIDX_ONE;
        end
    end

    always_comb begin
        pend_d = pend_q;
        hold_d = hold_q;
        n_drop = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_golden[i] && (!pend_q[i] || grant[i])) begin
                pend_d[i] = 1'b1;
                hold_d[i] = core_nonce[i*NONCE_W +: NONCE_W];
            end else if (core_golden[i]) begin
                n_drop = n_drop + 5'd1;
            end else if (grant[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + {12'd0, n_drop};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q || (n_drop != '0);
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            push_vld_q <= 1'b0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            presc_q    <= '0;
            led_sel_q  <= '0;
            leds_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
            push_vld_q <= grant_vld;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            presc_q    <= presc_q + PRESC_ONE;
            if (&presc_q) begin
                led_sel_q <= (int'(led_sel_q) == NUM_CORES - 1) ? '0 : led_sel_q + CIDX_ONE;
            end
            leds_q <= core_nonce[int'(led_sel_q)*NONCE_W + 8 +: LED_W];
        end
    end

    always_ff @(posedge hash_clk) begin
        hold_q <= hold_d;
        if (grant_vld) begin
            push_data_q <= {grant_idx, hold_q[grant_idx]};
        end
    end

    ltcminer_nonce_hub_fifo #(
        .WIDTH (CIDX_W + NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (hash_clk),
        .rst_i   (reset),
        .push_i  (push_vld_q),
        .wdata_i (push_data_q),
        .pop_i   (gn_valid && gn_ready),
        .rdata_o ({gn_core, gn_nonce}),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign gn_valid = !fifo_empty;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;
    assign LEDS_out = leds_q;

endmodule

// File: tb/tb_ltcminer_nonce_hub.sv
// Scenario-driven bench for ltcminer_nonce_hub (4 cores, 4-deep FIFO, 16-cycle LED step).
module tb_ltcminer_nonce_hub;

    localparam int NUM_CORES  = 4;
    localparam int PREFIX_W   = 4;
    localparam int NONCE_W    = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int LED_W      = 8;
    localparam int LED_DIV    = 4;

    logic                          hash_clk = 1'b0;
    logic                          reset = 1'b1;
    logic [NUM_CORES*PREFIX_W-1:0] core_nonce_msb;
    logic [NUM_CORES*NONCE_W-1:0]  core_nonce = '0;
    logic [NUM_CORES-1:0]          core_golden = '0;
    logic                          gn_valid;
    logic                          gn_ready = 1'b0;
    logic [NONCE_W-1:0]            gn_nonce;
    logic [1:0]                    gn_core;
    logic [15:0]                   drop_cnt;
    logic                          overflow;
    logic [LED_W-1:0]              LEDS_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  core;
        logic [31:0] nonce;
    } rec_t;

    always #5 hash_clk = ~hash_clk;

    ltcminer_nonce_hub #(
        .NUM_CORES  (NUM_CORES),
        .PREFIX_W   (PREFIX_W),
        .NONCE_W    (NONCE_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LED_W      (LED_W),
        .LED_DIV    (LED_DIV)
    ) dut (
        .hash_clk       (hash_clk),
        .reset          (reset),
        .core_nonce_msb (core_nonce_msb),
        .core_nonce     (core_nonce),
        .core_golden    (core_golden),
        .gn_valid       (gn_valid),
        .gn_ready       (gn_ready),
        .gn_nonce       (gn_nonce),
        .gn_core        (gn_core),
        .drop_cnt       (drop_cnt),
        .overflow       (overflow),
        .LEDS_out       (LEDS_out)
    );

    task automatic set_nonce(input int c, input logic [31:0] v);
        core_nonce[c*NONCE_W +: NONCE_W] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        core_golden = '0;
        gn_ready = 1'b0;
        @(negedge hash_clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp_msb;
        for (int i = 0; i < NUM_CORES; i++) set_nonce(i, $urandom);
        do_reset();
        for (int i = 0; i < NUM_CORES; i++) exp_msb[i*4 +: 4] = 4'(i);
        checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", gn_valid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (LEDS_out !== 8'd0) begin errors++; $display("FAIL reset_leds: got %h expected 00", LEDS_out); end
        checks++; if (core_nonce_msb !== exp_msb) begin errors++; $display("FAIL prefix: got %h expected %h", core_nonce_msb, exp_msb); end
    endtask

    task automatic test_single();
        do_reset();
        gn_ready = 1'b1;
        repeat (3) @(negedge hash_clk);
        set_nonce(2, 32'hDEADBEEF);
        core_golden = 4'b0100;
        @(negedge hash_clk);
        core_golden = '0;
        @(negedge hash_clk);
        checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", gn_valid); end
        @(negedge hash_clk);
        checks++; if (gn_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", gn_valid); end
        checks++; if (gn_nonce !== 32'hDEADBEEF) begin errors++; $display("FAIL single_nonce: got %h expected deadbeef", gn_nonce); end
        checks++; if (gn_core !== 2'd2) begin errors++; $display("FAIL single_core: got %0d expected 2", gn_core); end
        @(negedge hash_clk);
        checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b expected 0", gn_valid); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] n [NUM_CORES];
        do_reset();
        gn_ready = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            n[i] = $urandom;
            set_nonce(i, n[i]);
        end
        core_golden = '1;
        @(negedge hash_clk);
        core_golden = '0;
        @(negedge hash_clk);
        for (int i = 0; i < NUM_CORES; i++) begin
            @(negedge hash_clk);
            checks++;
            if (gn_valid !== 1'b1 || gn_core !== 2'(i) || gn_nonce !== n[i]) begin
                errors++;
                $display("FAIL simul_order%0d: got v=%b core=%0d nonce=%h expected v=1 core=%0d nonce=%h",
                         i, gn_valid, gn_core, gn_nonce, i, n[i]);
            end
        end
        @(negedge hash_clk);
        checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b expected 0", gn_valid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL simul_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_fairness();
        logic [31:0] n3;
        int seen_at;
        logic [31:0] seen_nonce;
        do_reset();
        gn_ready = 1'b1;
        n3 = $urandom;
        seen_at = -1;
        seen_nonce = '0;
        for (int c = 0; c < 14; c++) begin
            core_golden = 4'b0001;
            set_nonce(0, $urandom);
            if (c == 3) begin
                core_golden[3] = 1'b1;
                set_nonce(3, n3);
            end
            if (seen_at < 0 && gn_valid && gn_core == 2'd3) begin
                seen_at = c;
                seen_nonce = gn_nonce;
            end
            @(negedge hash_clk);
        end
        core_golden = '0;
        // Captured at the 4th edge; a grant within 4 more edges is visible by iteration 9.
        checks++;
        if (seen_at < 0 || seen_at > 9) begin
            errors++;
            $display("FAIL fairness_latency: got iteration %0d expected 4..9", seen_at);
        end
        checks++; if (seen_nonce !== n3) begin errors++; $display("FAIL fairness_nonce: got %h expected %h", seen_nonce, n3); end
    endtask

    task automatic test_backpressure();
        logic [31:0] n [6];
        logic [31:0] got [$];
        do_reset();
        gn_ready = 1'b0;
        for (int j = 0; j < 6; j++) n[j] = $urandom;
        for (int c = 0; c < 11; c++) begin
            core_golden = '0;
            if (c % 2 == 0) begin
                set_nonce(1, n[c/2]);
                core_golden = 4'b0010;
            end
            @(negedge hash_clk);
        end
        core_golden = '0;
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop: got %0d expected 1", drop_cnt); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        checks++;
        if (gn_valid !== 1'b1 || gn_nonce !== n[0]) begin
            errors++;
            $display("FAIL bp_head: got v=%b nonce=%h expected v=1 nonce=%h", gn_valid, gn_nonce, n[0]);
        end
        gn_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (gn_valid) got.push_back(gn_nonce);
            @(negedge hash_clk);
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got.size()); end
        for (int j = 0; j < 5 && j < got.size(); j++) begin
            checks++;
            if (got[j] !== n[j]) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", j, got[j], n[j]); end
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] n [2];
        rec_t got [$];
        do_reset();
        gn_ready = 1'b1;
        n[0] = $urandom;
        n[1] = $urandom;
        for (int j = 0; j < 2; j++) begin
            set_nonce(1, n[j]);
            core_golden = 4'b0010;
            @(negedge hash_clk);
        end
        core_golden = '0;
        for (int c = 0; c < 10; c++) begin
            if (gn_valid) got.push_back('{core: gn_core, nonce: gn_nonce});
            @(negedge hash_clk);
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL same_count: got %0d expected 2", got.size()); end
        for (int j = 0; j < 2 && j < got.size(); j++) begin
            checks++;
            if (got[j].nonce !== n[j] || got[j].core !== 2'd1) begin
                errors++;
                $display("FAIL same_result%0d: got core=%0d nonce=%h expected core=1 nonce=%h",
                         j, got[j].core, got[j].nonce, n[j]);
            end
        end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL same_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        logic stale;
        do_reset();
        gn_ready = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) set_nonce(i, $urandom | 32'h0000_FF00);
        for (int c = 0; c < 7; c++) begin
            core_golden = (c % 2 == 0 && c < 6) ? 4'b0100 : 4'b0000;
            set_nonce(2, $urandom);
            @(negedge hash_clk);
        end
        core_golden = 4'b1010;
        @(negedge hash_clk);
        core_golden = 4'b0010;
        @(negedge hash_clk);
        core_golden = '0;
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL mid_predrop: got %0d expected 1", drop_cnt); end
        reset = 1'b1;
        @(negedge hash_clk);
        reset = 1'b0;
        checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", gn_valid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL mid_drop: got %0d expected 0", drop_cnt); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
        checks++; if (LEDS_out !== 8'd0) begin errors++; $display("FAIL mid_leds: got %h expected 00", LEDS_out); end
        gn_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (gn_valid !== 1'b0) stale = 1'b1;
            @(negedge hash_clk);
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b expected 0", stale); end
    endtask

    task automatic test_leds();
        logic [31:0] n [NUM_CORES];
        int sel;
        logic [7:0] exp_led;
        for (int i = 0; i < NUM_CORES; i++) begin
            n[i] = $urandom;
            set_nonce(i, n[i]);
        end
        do_reset();
        for (int e = 1; e <= 72; e++) begin
            @(negedge hash_clk);
            sel = ((e - 1) / 16) % NUM_CORES;
            exp_led = n[sel][15:8];
            checks++;
            if (LEDS_out !== exp_led) begin
                errors++;
                $display("FAIL leds_e%0d: got %h expected %h (core %0d)", e, LEDS_out, exp_led, sel);
            end
        end
    endtask

    task automatic test_random();
        rec_t sb [$];
        logic [3:0] gold;
        logic ready;
        logic prev_stall;
        logic [31:0] prev_n;
        logic [1:0] prev_c;
        logic [11:0] serial;
        logic [31:0] v;
        int idx;
        int skipped;
        int drops_model;
        do_reset();
        prev_stall = 1'b0;
        prev_n = '0;
        prev_c = '0;
        serial = '0;
        skipped = 0;
        for (int c = 0; c < 600; c++) begin
            gold = '0;
            ready = 1'b1;
            if (c < 500) begin
                for (int i = 0; i < NUM_CORES; i++) gold[i] = ($urandom_range(3) == 0);
                ready = ($urandom_range(2) != 0);
            end
            if (prev_stall) begin
                checks++;
                if (gn_valid !== 1'b1 || gn_nonce !== prev_n || gn_core !== prev_c) begin
                    errors++;
                    $display("FAIL rnd_stable c%0d: got v=%b core=%0d nonce=%h expected v=1 core=%0d nonce=%h",
                             c, gn_valid, gn_core, gn_nonce, prev_c, prev_n);
                end
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                v = {4'(i), serial, 16'($urandom)};
                set_nonce(i, v);
                if (gold[i]) sb.push_back('{core: 2'(i), nonce: v});
            end
            serial = serial + 12'd1;
            core_golden = gold;
            gn_ready = ready;
            if (gn_valid && gn_ready) begin
                idx = -1;
                for (int k = 0; k < sb.size(); k++) begin
                    if (idx < 0 && sb[k].core == gn_core && sb[k].nonce == gn_nonce) idx = k;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected c%0d: got core=%0d nonce=%h expected a pending pulse of that core",
                             c, gn_core, gn_nonce);
                end else begin
                    // Older pulses from the same core that were never delivered were lost.
                    for (int k = idx; k >= 0; k--) begin
                        if (sb[k].core == gn_core) begin
                            if (k != idx) skipped++;
                            sb.delete(k);
                        end
                    end
                end
            end
            prev_stall = gn_valid && !gn_ready;
            prev_n = gn_nonce;
            prev_c = gn_core;
            @(negedge hash_clk);
        end
        core_golden = '0;
        drops_model = skipped + sb.size();
        checks++;
        if (drop_cnt !== 16'(drops_model)) begin
            errors++;
            $display("FAIL rnd_drop: got %0d expected %0d", drop_cnt, drops_model);
        end
        checks++;
        if (overflow !== (drops_model > 0)) begin
            errors++;
            $display("FAIL rnd_overflow: got %b expected %b", overflow, drops_model > 0);
        end
        checks++; if (gn_valid !== 1'b0) begin errors++; $display("FAIL rnd_drained: got %b expected 0", gn_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_leds();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
